// File: rtl/cdc_xfer_arbiter.sv
// Launch side of a toggle-handshake CDC channel shared by N requesters.
// Round-robin arbitration, held data word, and a two-flop ack synchroniser.
module cdc_xfer_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clkA,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    grant,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic            xfer_toggle,
  output logic [W-1:0]    xfer_data,
  output logic [SW-1:0]   xfer_src,
  input  logic            ack_toggle_async,
  output logic            protocol_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t        state_r;
  logic [1:0]    ackSync_r;
  logic          mismatch_r;
  logic [SW-1:0] ptr_r;

  logic          match_s;
  logic          found_s;
  logic [SW-1:0] winner_s;
  logic [SW-1:0] cand_s;
  logic [SW-1:0] ptrNext_s;

  assign match_s      = (ackSync_r[1] == xfer_toggle);
  assign busy         = (state_r != IDLE);
  assign protocol_err = (state_r == IDLE) && !match_s && !mismatch_r;

  // Round-robin search: first requester at or above ptr, wrapping to 0.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(ptr_r) + i >= N) begin
        cand_s = SW'(int'(ptr_r) + i - N);
      end else begin
        cand_s = SW'(int'(ptr_r) + i);
      end
      if (!found_s && req[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    if (winner_s == SW'(N - 1)) begin
      ptrNext_s = '0;
    end else begin
      ptrNext_s = winner_s + 1'b1;
    end
  end

  // Handshake FSM, ack synchroniser and all registered outputs.
  always_ff @(posedge clkA) begin
    if (rst) begin
      state_r     <= IDLE;
      ackSync_r   <= 2'b00;
      mismatch_r  <= 1'b0;
      ptr_r       <= '0;
      grant       <= '0;
      done        <= '0;
      xfer_toggle <= 1'b0;
      xfer_data   <= '0;
      xfer_src    <= '0;
    end else begin
      ackSync_r  <= {ackSync_r[0], ack_toggle_async};
      mismatch_r <= (state_r == IDLE) && !match_s;
      done       <= '0;
      case (state_r)
        IDLE: begin
          if (found_s && match_s) begin
            xfer_data   <= req_data[winner_s*W +: W];
            xfer_src    <= winner_s;
            grant       <= {{(N-1){1'b0}}, 1'b1} << winner_s;
            xfer_toggle <= ~xfer_toggle;
            ptr_r       <= ptrNext_s;
            state_r     <= WAIT;
          end
        end
        WAIT: begin
          if (match_s) begin
            done    <= {{(N-1){1'b0}}, 1'b1} << xfer_src;
            grant   <= '0;
            state_r <= COOL;
          end
        end
        // One dead cycle so a requester clearing req on done is not re-granted.
        COOL: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed bench for cdc_xfer_arbiter: the bench plays the destination side
// by echoing xfer_toggle back on ack_toggle_async.
module tb_cdc_xfer_arbiter;

  logic        clkA = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        xfer_toggle;
  logic [7:0]  xfer_data;
  logic [1:0]  xfer_src;
  logic        ack_toggle_async;
  logic        protocol_err;

  int checks = 0;
  int failures = 0;

  cdc_xfer_arbiter #(.N(4), .W(8)) dut (
    .clkA(clkA),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .done(done),
    .busy(busy),
    .xfer_toggle(xfer_toggle),
    .xfer_data(xfer_data),
    .xfer_src(xfer_src),
    .ack_toggle_async(ack_toggle_async),
    .protocol_err(protocol_err)
  );

  always #5 clkA = ~clkA;

  task automatic tick();
    @(posedge clkA);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer with req already applied; ack echoed right after launch.
  task automatic xfer(input string tag, input logic [3:0] g, input logic t,
                      input logic [7:0] d, input logic [1:0] s);
    tick();
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_toggle"}, 32'(xfer_toggle), 32'(t));
    chk({tag, "_data"}, 32'(xfer_data), 32'(d));
    chk({tag, "_src"}, 32'(xfer_src), 32'(s));
    ack_toggle_async = t;
    tick();
    tick();
    tick();
    chk({tag, "_done"}, 32'(done), 32'(g));
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    req_data = 32'h0;
    ack_toggle_async = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_toggle", 32'(xfer_toggle), 32'd0);
    chk("rst_data", 32'(xfer_data), 32'd0);
    chk("rst_src", 32'(xfer_src), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);

    // Single transfer, ack echoed three cycles after launch.
    req = 4'b0010;
    req_data = 32'h0000A500;
    tick();
    chk("single_grant", 32'(grant), 32'h2);
    chk("single_toggle", 32'(xfer_toggle), 32'd1);
    chk("single_data", 32'(xfer_data), 32'hA5);
    chk("single_src", 32'(xfer_src), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    tick();
    ack_toggle_async = 1'b1;
    tick();
    chk("single_done_e0", 32'(done), 32'd0);
    tick();
    chk("single_done_e1", 32'(done), 32'd0);
    tick();
    chk("single_done_e2", 32'(done), 32'h2);
    chk("single_grant_off", 32'(grant), 32'd0);
    chk("single_busy_cool", 32'(busy), 32'd1);
    req = 4'b0000;
    tick();
    chk("single_done_e3", 32'(done), 32'd0);
    chk("single_busy_off", 32'(busy), 32'd0);
    chk("single_data_hold", 32'(xfer_data), 32'hA5);

    // Reset with ack returned to match the reset toggle value.
    rst = 1'b1;
    ack_toggle_async = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Round-robin with all four requesting.
    req = 4'b1111;
    req_data = 32'hDDCCBBAA;
    xfer("rr0", 4'b0001, 1'b1, 8'hAA, 2'd0);
    xfer("rr1", 4'b0010, 1'b0, 8'hBB, 2'd1);
    xfer("rr2", 4'b0100, 1'b1, 8'hCC, 2'd2);
    xfer("rr3", 4'b1000, 1'b0, 8'hDD, 2'd3);
    xfer("rr4", 4'b0001, 1'b1, 8'hAA, 2'd0);
    req = 4'b0000;

    // Wrap and skip: after requester 2, ptr=3 so 0 wins, then 2.
    rst = 1'b1;
    ack_toggle_async = 1'b0;
    tick();
    rst = 1'b0;
    req_data = 32'h44332211;
    req = 4'b0100;
    xfer("wrap_a", 4'b0100, 1'b1, 8'h33, 2'd2);
    req = 4'b0101;
    xfer("wrap_b", 4'b0001, 1'b0, 8'h11, 2'd0);
    xfer("wrap_c", 4'b0100, 1'b1, 8'h33, 2'd2);
    req = 4'b0000;

    // Held data stability while waiting for ack.
    req = 4'b0001;
    tick();
    chk("hold_grant0", 32'(grant), 32'h1);
    chk("hold_toggle", 32'(xfer_toggle), 32'd0);
    req_data = 32'hFFFFFFFF;
    req = 4'b1110;
    tick();
    tick();
    chk("hold_grant", 32'(grant), 32'h1);
    chk("hold_data", 32'(xfer_data), 32'h11);
    chk("hold_src", 32'(xfer_src), 32'd0);
    ack_toggle_async = 1'b0;
    tick();
    tick();
    tick();
    chk("hold_done", 32'(done), 32'h1);
    req = 4'b0000;
    tick();
    chk("hold_idle", 32'(busy), 32'd0);

    // Spurious ack in IDLE with xfer_toggle=0.
    ack_toggle_async = 1'b1;
    tick();
    chk("spur_perr_early", 32'(protocol_err), 32'd0);
    tick();
    chk("spur_perr", 32'(protocol_err), 32'd1);
    req = 4'b0001;
    tick();
    chk("spur_perr_once", 32'(protocol_err), 32'd0);
    chk("spur_blocked", 32'(grant), 32'd0);
    tick();
    chk("spur_blocked2", 32'(grant), 32'd0);
    ack_toggle_async = 1'b0;
    tick();
    tick();
    chk("spur_still_blocked", 32'(grant), 32'd0);
    tick();
    chk("spur_resume_grant", 32'(grant), 32'h1);
    chk("spur_resume_toggle", 32'(xfer_toggle), 32'd1);
    chk("spur_resume_data", 32'(xfer_data), 32'hFF);

    // Reset while in WAIT, then the stale ack arrives.
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_toggle", 32'(xfer_toggle), 32'd0);
    chk("midrst_data", 32'(xfer_data), 32'd0);
    chk("midrst_src", 32'(xfer_src), 32'd0);
    ack_toggle_async = 1'b1;
    tick();
    chk("midrst_perr0", 32'(protocol_err), 32'd0);
    tick();
    chk("midrst_perr1", 32'(protocol_err), 32'd1);
    chk("midrst_nodone1", 32'(done), 32'd0);
    tick();
    chk("midrst_perr2", 32'(protocol_err), 32'd0);
    chk("midrst_nodone2", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
